// File: rtl/ex_mem.sv
// ex_mem: EX -> MEM pipeline register for the 5-stage MIPS32 core.
// Latches the write-back triple (and optionally HI/LO), applies the stall
// vector and flush, and feeds multi-cycle accumulate state back to EX.
// Optional feature macro: EX_MEM_HILO_EN registers ex_whilo/ex_hi/ex_lo;
// without it mem_whilo/mem_hi/mem_lo are tied to zero.
module ex_mem #(
  parameter int REG_W  = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [5:0]           stall,
  input  logic                 flush,
  input  logic [ADDR_W-1:0]    ex_wd,
  input  logic                 ex_wreg,
  input  logic [REG_W-1:0]     ex_wdata,
  input  logic                 ex_whilo,
  input  logic [REG_W-1:0]     ex_hi,
  input  logic [REG_W-1:0]     ex_lo,
  input  logic [2*REG_W-1:0]   hilo_i,
  input  logic [CNT_W-1:0]     cnt_i,
  output logic [ADDR_W-1:0]    mem_wd,
  output logic                 mem_wreg,
  output logic [REG_W-1:0]     mem_wdata,
  output logic                 mem_whilo,
  output logic [REG_W-1:0]     mem_hi,
  output logic [REG_W-1:0]     mem_lo,
  output logic [2*REG_W-1:0]   hilo_o,
  output logic [CNT_W-1:0]     cnt_o
);

  // Stall decode: only bits 3 (EX) and 4 (MEM) matter to this stage.
  // EX stalled with MEM running inserts a bubble; both clear lets EX advance;
  // anything else (both stalled, or the illegal MEM-only stall) holds.
  logic w_bubble;
  logic w_advance;
  logic w_unused_stall;

  assign w_bubble       = stall[3] & ~stall[4];
  assign w_advance      = ~stall[3] & ~stall[4];
  assign w_unused_stall = ^{stall[5], stall[2:0]};

  logic [ADDR_W-1:0]  r_wd;
  logic               r_wreg;
  logic [REG_W-1:0]   r_wdata;
  logic [2*REG_W-1:0] r_hilo;
  logic [CNT_W-1:0]   r_cnt;

  // Write-back triple: clear on reset/flush/bubble, load on advance, else hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wd    <= '0;
      r_wreg  <= 1'b0;
      r_wdata <= '0;
    end else if (flush || w_bubble) begin
      r_wd    <= '0;
      r_wreg  <= 1'b0;
      r_wdata <= '0;
    end else if (w_advance) begin
      r_wd    <= ex_wd;
      r_wreg  <= ex_wreg;
      r_wdata <= ex_wdata;
    end
  end

  // Accumulate state: captured while EX is stalled mid-sequence, cleared once
  // EX advances (sequence done) or on flush, held when MEM is stalled too.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hilo <= '0;
      r_cnt  <= '0;
    end else if (flush) begin
      r_hilo <= '0;
      r_cnt  <= '0;
    end else if (w_bubble) begin
      r_hilo <= hilo_i;
      r_cnt  <= cnt_i;
    end else if (w_advance) begin
      r_hilo <= '0;
      r_cnt  <= '0;
    end
  end

  assign mem_wd    = r_wd;
  assign mem_wreg  = r_wreg;
  assign mem_wdata = r_wdata;
  assign hilo_o    = r_hilo;
  assign cnt_o     = r_cnt;

`ifdef EX_MEM_HILO_EN
  logic               r_whilo;
  logic [REG_W-1:0]   r_hi;
  logic [REG_W-1:0]   r_lo;

  // HI/LO write-back fields follow exactly the same rules as the triple.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_whilo <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else if (flush || w_bubble) begin
      r_whilo <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else if (w_advance) begin
      r_whilo <= ex_whilo;
      r_hi    <= ex_hi;
      r_lo    <= ex_lo;
    end
  end

  assign mem_whilo = r_whilo;
  assign mem_hi    = r_hi;
  assign mem_lo    = r_lo;
`else
  // HI/LO path not built: outputs are constant zero, inputs are ignored.
  logic w_unused_hilo;

  assign w_unused_hilo = ^{ex_whilo, ex_hi, ex_lo};
  assign mem_whilo     = 1'b0;
  assign mem_hi        = '0;
  assign mem_lo        = '0;
`endif

endmodule

// File: tb/tb_ex_mem.sv
// tb_ex_mem: scoreboard bench for ex_mem. Stimulus pushes hand-computed
// expected outputs into a queue; a monitor pops and compares after each
// rising edge (or after an asynchronous-reset probe).
module tb_ex_mem;

`ifdef EX_MEM_HILO_EN
  localparam bit HILO = 1'b1;
`else
  localparam bit HILO = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [4:0]  ex_wd;
  logic        ex_wreg;
  logic [31:0] ex_wdata;
  logic        ex_whilo;
  logic [31:0] ex_hi;
  logic [31:0] ex_lo;
  logic [63:0] hilo_i;
  logic [1:0]  cnt_i;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic        mem_whilo;
  logic [31:0] mem_hi;
  logic [31:0] mem_lo;
  logic [63:0] hilo_o;
  logic [1:0]  cnt_o;

  always #5 clk = ~clk;

  ex_mem dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
    .ex_whilo(ex_whilo), .ex_hi(ex_hi), .ex_lo(ex_lo),
    .hilo_i(hilo_i), .cnt_i(cnt_i),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
    .hilo_o(hilo_o), .cnt_o(cnt_o)
  );

  typedef struct {
    logic [5:0]  stall;
    logic        flush;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic        whilo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [63:0] hilo;
    logic [1:0]  cnt;
  } in_t;

  typedef struct {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic        whilo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [63:0] hilo;
    logic [1:0]  cnt;
  } out_t;

  out_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_txn    = 0;
  event async_ev;

  function automatic in_t mki(logic [5:0] s, logic f, logic [4:0] wd, logic wreg,
                              logic [31:0] wdata, logic whilo, logic [31:0] hi,
                              logic [31:0] lo, logic [63:0] hilo, logic [1:0] cnt);
    in_t r;
    r.stall = s; r.flush = f; r.wd = wd; r.wreg = wreg; r.wdata = wdata;
    r.whilo = whilo; r.hi = hi; r.lo = lo; r.hilo = hilo; r.cnt = cnt;
    return r;
  endfunction

  // HI/LO expectations are zero unless the optional path is built.
  function automatic out_t mko(logic [4:0] wd, logic wreg, logic [31:0] wdata,
                               logic whilo, logic [31:0] hi, logic [31:0] lo,
                               logic [63:0] hilo, logic [1:0] cnt);
    out_t r;
    r.wd = wd; r.wreg = wreg; r.wdata = wdata;
    r.whilo = HILO ? whilo : 1'b0;
    r.hi    = HILO ? hi : 32'h0;
    r.lo    = HILO ? lo : 32'h0;
    r.hilo = hilo; r.cnt = cnt;
    return r;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s txn %0d: got %h expected %h", name, n_txn, act, req);
    end
  endtask

  task automatic drive(in_t i);
    stall = i.stall; flush = i.flush; ex_wd = i.wd; ex_wreg = i.wreg;
    ex_wdata = i.wdata; ex_whilo = i.whilo; ex_hi = i.hi; ex_lo = i.lo;
    hilo_i = i.hilo; cnt_i = i.cnt;
  endtask

  // One clocked transaction: drive on the falling edge, expect after the rise.
  task automatic step(in_t i, out_t e);
    @(negedge clk);
    drive(i);
    exp_q.push_back(e);
  endtask

  // Monitor: compare after every rising edge or asynchronous-reset probe.
  initial begin
    out_t e;
    forever begin
      @(posedge clk or async_ev);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_txn++;
        chk("mem_wd",    {59'd0, mem_wd},    {59'd0, e.wd});
        chk("mem_wreg",  {63'd0, mem_wreg},  {63'd0, e.wreg});
        chk("mem_wdata", {32'd0, mem_wdata}, {32'd0, e.wdata});
        chk("mem_whilo", {63'd0, mem_whilo}, {63'd0, e.whilo});
        chk("mem_hi",    {32'd0, mem_hi},    {32'd0, e.hi});
        chk("mem_lo",    {32'd0, mem_lo},    {32'd0, e.lo});
        chk("hilo_o",    hilo_o,             e.hilo);
        chk("cnt_o",     {62'd0, cnt_o},     {62'd0, e.cnt});
        $display("txn %0d: wd=%0d wreg=%0b wdata=%h hi=%h lo=%h hilo=%h cnt=%0d",
                 n_txn, mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, hilo_o, cnt_o);
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    out_t z;
    z = mko(5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 64'h0, 2'd0);

    rst = 1'b0;
    drive(mki(6'b0, 1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 64'h0, 2'd0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    // First edge after release copies EX fields.
    step(mki(6'b0, 1'b0, 5'd3, 1'b1, 32'h1234_5678, 1'b1, 32'h11, 32'h22, 64'hFFFF, 2'd2),
         mko(5'd3, 1'b1, 32'h1234_5678, 1'b1, 32'h11, 32'h22, 64'h0, 2'd0));
    // Capture accumulate state so reset has something nonzero to clear.
    step(mki(6'b001111, 1'b0, 5'd9, 1'b1, 32'h9, 1'b1, 32'h9, 32'h9, 64'h77_0000_0077, 2'd2),
         mko(5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 64'h77_0000_0077, 2'd2));

    // Asynchronous reset between edges, random inputs, no clock edge.
    @(negedge clk);
    drive(mki(6'($urandom), 1'b0, 5'($urandom), 1'b1, $urandom, 1'b1, $urandom, $urandom,
              {$urandom, $urandom}, 2'($urandom)));
    #1;
    rst = 1'b0;
    exp_q.push_back(z);
    ->async_ev;
    #2;
    @(negedge clk);
    rst = 1'b1;

    // Release then first edge copies EX fields again.
    step(mki(6'b0, 1'b0, 5'd3, 1'b1, 32'h1234_5678, 1'b0, 32'h0, 32'h0, 64'h0, 2'd0),
         mko(5'd3, 1'b1, 32'h1234_5678, 1'b0, 32'h0, 32'h0, 64'h0, 2'd0));
    // Pass-through.
    step(mki(6'b0, 1'b0, 5'd31, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0, 32'h0, 64'h5, 2'd1),
         mko(5'd31, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0, 32'h0, 64'h0, 2'd0));
    // Bubble with accumulate capture.
    step(mki(6'b001111, 1'b0, 5'd4, 1'b1, 32'h4444, 1'b1, 32'h3, 32'h4, 64'h1_0000_0002, 2'd1),
         mko(5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 64'h1_0000_0002, 2'd1));
    // Advance: accumulate cleared, HI/LO passed.
    step(mki(6'b0, 1'b0, 5'd7, 1'b0, 32'h0000_00FF, 1'b1, 32'h1, 32'h2, 64'hABCD, 2'd3),
         mko(5'd7, 1'b0, 32'h0000_00FF, 1'b1, 32'h1, 32'h2, 64'h0, 2'd0));
    // Load A5A5A5A5, then hold three cycles with changing inputs.
    step(mki(6'b0, 1'b0, 5'd10, 1'b1, 32'hA5A5_A5A5, 1'b1, 32'hAAAA, 32'h5555, 64'h0, 2'd0),
         mko(5'd10, 1'b1, 32'hA5A5_A5A5, 1'b1, 32'hAAAA, 32'h5555, 64'h0, 2'd0));
    for (int k = 0; k < 3; k++) begin
      step(mki(6'b011111, 1'b0, 5'(k + 1), 1'b0, 32'h100 + 32'(k), 1'b0, 32'(k), 32'(k),
               64'h99 + 64'(k), 2'(k)),
           mko(5'd10, 1'b1, 32'hA5A5_A5A5, 1'b1, 32'hAAAA, 32'h5555, 64'h0, 2'd0));
    end
    // Illegal MEM-only stall also holds.
    step(mki(6'b010000, 1'b0, 5'd20, 1'b0, 32'h2020, 1'b0, 32'h0, 32'h0, 64'h1234, 2'd1),
         mko(5'd10, 1'b1, 32'hA5A5_A5A5, 1'b1, 32'hAAAA, 32'h5555, 64'h0, 2'd0));
    // Bubble capturing count 3 unchanged, then hold keeps accumulate state.
    step(mki(6'b001111, 1'b0, 5'd2, 1'b1, 32'h2, 1'b1, 32'h2, 32'h2, 64'h0123_4567_89AB_CDEF, 2'd3),
         mko(5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 64'h0123_4567_89AB_CDEF, 2'd3));
    step(mki(6'b011111, 1'b0, 5'd6, 1'b1, 32'h6, 1'b1, 32'h6, 32'h6, 64'h6, 2'd0),
         mko(5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 64'h0123_4567_89AB_CDEF, 2'd3));
    // Flush overrides bubble: accumulate cleared too.
    step(mki(6'b001111, 1'b1, 5'd8, 1'b1, 32'h8888, 1'b1, 32'h8, 32'h8, 64'h8888, 2'd2), z);
    // Load, then flush overrides a full hold.
    step(mki(6'b0, 1'b0, 5'd5, 1'b1, 32'h55, 1'b1, 32'h5, 32'h6, 64'h0, 2'd0),
         mko(5'd5, 1'b1, 32'h55, 1'b1, 32'h5, 32'h6, 64'h0, 2'd0));
    step(mki(6'b011111, 1'b1, 5'd9, 1'b1, 32'h99, 1'b1, 32'h9, 32'h9, 64'h9, 2'd1), z);
    // Normal flow resumes after flush.
    step(mki(6'b0, 1'b0, 5'd1, 1'b1, 32'h1, 1'b0, 32'h0, 32'h0, 64'h0, 2'd0),
         mko(5'd1, 1'b1, 32'h1, 1'b0, 32'h0, 32'h0, 64'h0, 2'd0));

    // Drain: allow the last expectation to be consumed.
    @(negedge clk);
    drive(mki(6'b011111, 1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 64'h0, 2'd0));
    repeat (2) @(negedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
